// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
// Stepped-frequency sweep sequencer for a 32-bit phase-accumulator NCO.
// Owns the NCO phase increment, reset_n and clken. For each sweep it resets
// the NCO, waits for output validity, then dwells on each tone before
// stepping the phase increment. The NCO phase stays continuous between tones.
//
// Build option: define SWEEP_PINGPONG_EN to enable up/down round-trip sweeps.
// This adds the cfg_repeat port. Without the macro the sweep runs upward once.
module nco_sweep_ctrl #(
  parameter int PHI_W      = 32,
  parameter int DWELL_W    = 16,
  parameter int RST_CYCLES = 14,
  parameter int SETTLE_MAX = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PHI_W-1:0]   cfg_start_inc,
  input  logic [PHI_W-1:0]   cfg_step_inc,
  input  logic [PHI_W-1:0]   cfg_stop_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef SWEEP_PINGPONG_EN
  input  logic [7:0]         cfg_repeat,
`endif
  input  logic               nco_valid,
  output logic [PHI_W-1:0]   nco_phi_inc,
  output logic               nco_reset_n,
  output logic               nco_clken,
  output logic               tone_valid,
  output logic [15:0]        tone_idx,
  output logic               busy,
  output logic               done,
  output logic               err_timeout
);

  // Counter widths sized to hold RST_CYCLES-1 and SETTLE_MAX-1.
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SC_W = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NCORST = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  // Saturating tone index increment: the index sticks at all-ones.
  function automatic logic [15:0] idx_sat_inc(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Registered state
  state_t              state_r;
  logic [PHI_W-1:0]    start_inc_r;
  logic [PHI_W-1:0]    step_r;
  logic [PHI_W-1:0]    stop_r;
  logic [DWELL_W-1:0]  dwell_r;
  logic [RC_W-1:0]     rst_cnt_r;
  logic [SC_W-1:0]     settle_cnt_r;
  logic [DWELL_W-1:0]  dwell_cnt_r;
  logic [PHI_W-1:0]    phi_r;
  logic [15:0]         idx_r;
  logic                busy_r;
  logic                done_r;
  logic                tone_valid_r;
  logic                nco_reset_n_r;
  logic                nco_clken_r;
  logic                err_r;
`ifdef SWEEP_PINGPONG_EN
  logic                dir_r;   // 0 = stepping up, 1 = stepping down
  logic [7:0]          rep_r;   // round trips remaining, including current
`endif

  // Next-state values
  state_t              state_nxt_s;
  logic [PHI_W-1:0]    start_inc_nxt_s;
  logic [PHI_W-1:0]    step_nxt_s;
  logic [PHI_W-1:0]    stop_nxt_s;
  logic [DWELL_W-1:0]  dwell_nxt_s;
  logic [RC_W-1:0]     rst_cnt_nxt_s;
  logic [SC_W-1:0]     settle_cnt_nxt_s;
  logic [DWELL_W-1:0]  dwell_cnt_nxt_s;
  logic [PHI_W-1:0]    phi_nxt_s;
  logic [15:0]         idx_nxt_s;
  logic                busy_nxt_s;
  logic                done_nxt_s;
  logic                tone_valid_nxt_s;
  logic                nco_reset_n_nxt_s;
  logic                nco_clken_nxt_s;
  logic                err_nxt_s;
  logic                timeout_s;
  logic [PHI_W:0]      up_sum_s;
  logic                up_ok_s;
`ifdef SWEEP_PINGPONG_EN
  logic                dir_nxt_s;
  logic [7:0]          rep_nxt_s;
  logic [PHI_W:0]      dn_diff_s;
  logic                dn_ok_s;
`endif

  // Next-state, datapath and output decode; everything holds by default.
  always_comb begin
    state_nxt_s      = state_r;
    start_inc_nxt_s  = start_inc_r;
    step_nxt_s       = step_r;
    stop_nxt_s       = stop_r;
    dwell_nxt_s      = dwell_r;
    rst_cnt_nxt_s    = rst_cnt_r;
    settle_cnt_nxt_s = settle_cnt_r;
    dwell_cnt_nxt_s  = dwell_cnt_r;
    phi_nxt_s        = phi_r;
    idx_nxt_s        = idx_r;
    err_nxt_s        = err_r;
    timeout_s        = 1'b0;
`ifdef SWEEP_PINGPONG_EN
    dir_nxt_s        = dir_r;
    rep_nxt_s        = rep_r;
`endif

    // Candidate next tone with the carry kept so wrap-around ends the sweep.
    up_sum_s = {1'b0, phi_r} + {1'b0, step_r};
    up_ok_s  = (up_sum_s[PHI_W] == 1'b0) &&
               (up_sum_s[PHI_W-1:0] <= stop_r) &&
               (step_r != {PHI_W{1'b0}});
`ifdef SWEEP_PINGPONG_EN
    dn_diff_s = {1'b0, phi_r} - {1'b0, step_r};
    dn_ok_s   = (dn_diff_s[PHI_W] == 1'b0) &&
                (dn_diff_s[PHI_W-1:0] >= start_inc_r) &&
                (step_r != {PHI_W{1'b0}});
`endif

    case (state_r)
      ST_IDLE: begin
        // start wins over abort here; abort has no meaning while idle.
        if (start) begin
          start_inc_nxt_s = cfg_start_inc;
          step_nxt_s      = cfg_step_inc;
          stop_nxt_s      = cfg_stop_inc;
          if (cfg_dwell == {DWELL_W{1'b0}}) begin
            dwell_nxt_s = DWELL_W'(1'b1);
          end else begin
            dwell_nxt_s = cfg_dwell;
          end
          phi_nxt_s     = cfg_start_inc;
          idx_nxt_s     = 16'd0;
          err_nxt_s     = 1'b0;
          rst_cnt_nxt_s = RC_W'(RST_CYCLES - 1);
`ifdef SWEEP_PINGPONG_EN
          dir_nxt_s = 1'b0;
          if (cfg_repeat == 8'd0) begin
            rep_nxt_s = 8'd1;
          end else begin
            rep_nxt_s = cfg_repeat;
          end
`endif
          state_nxt_s = ST_NCORST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_NCORST: begin
        if (abort) begin
          state_nxt_s = ST_FIN;
        end else if (rst_cnt_r == {RC_W{1'b0}}) begin
          settle_cnt_nxt_s = {SC_W{1'b0}};
          state_nxt_s      = ST_SETTLE;
        end else begin
          rst_cnt_nxt_s = rst_cnt_r - RC_W'(1'b1);
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_nxt_s = ST_FIN;
        end else if (nco_valid) begin
          dwell_cnt_nxt_s = dwell_r;
          state_nxt_s     = ST_DWELL;
        end else if (settle_cnt_r == SC_W'(SETTLE_MAX - 1)) begin
          // Settle timeout: flag it, pulse done and skip FIN.
          err_nxt_s   = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r + SC_W'(1'b1);
        end
      end

      ST_DWELL: begin
        if (abort) begin
          state_nxt_s = ST_FIN;
        end else if (dwell_cnt_r == DWELL_W'(1'b1)) begin
`ifdef SWEEP_PINGPONG_EN
          if (!dir_r) begin
            if (up_ok_s) begin
              phi_nxt_s = up_sum_s[PHI_W-1:0];
              idx_nxt_s = idx_sat_inc(idx_r);
              dwell_cnt_nxt_s = dwell_r;
            end else if (dn_ok_s) begin
              // Turnaround: the top tone is not repeated.
              dir_nxt_s = 1'b1;
              phi_nxt_s = dn_diff_s[PHI_W-1:0];
              idx_nxt_s = idx_sat_inc(idx_r);
              dwell_cnt_nxt_s = dwell_r;
            end else begin
              state_nxt_s = ST_FIN;
            end
          end else begin
            if (dn_ok_s) begin
              phi_nxt_s = dn_diff_s[PHI_W-1:0];
              idx_nxt_s = idx_sat_inc(idx_r);
              dwell_cnt_nxt_s = dwell_r;
            end else if ((rep_r > 8'd1) && up_ok_s) begin
              rep_nxt_s = rep_r - 8'd1;
              dir_nxt_s = 1'b0;
              phi_nxt_s = up_sum_s[PHI_W-1:0];
              idx_nxt_s = idx_sat_inc(idx_r);
              dwell_cnt_nxt_s = dwell_r;
            end else begin
              state_nxt_s = ST_FIN;
            end
          end
`else
          if (up_ok_s) begin
            phi_nxt_s       = up_sum_s[PHI_W-1:0];
            idx_nxt_s       = idx_sat_inc(idx_r);
            dwell_cnt_nxt_s = dwell_r;
          end else begin
            state_nxt_s = ST_FIN;
          end
`endif
        end else begin
          dwell_cnt_nxt_s = dwell_cnt_r - DWELL_W'(1'b1);
        end
      end

      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave flops aligned
    // with the state they describe.
    busy_nxt_s        = (state_nxt_s != ST_IDLE);
    done_nxt_s        = (state_nxt_s == ST_FIN) || timeout_s;
    tone_valid_nxt_s  = (state_nxt_s == ST_DWELL);
    nco_reset_n_nxt_s = (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_DWELL);
    nco_clken_nxt_s   = (state_nxt_s != ST_IDLE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      start_inc_r   <= {PHI_W{1'b0}};
      step_r        <= {PHI_W{1'b0}};
      stop_r        <= {PHI_W{1'b0}};
      dwell_r       <= {DWELL_W{1'b0}};
      rst_cnt_r     <= {RC_W{1'b0}};
      settle_cnt_r  <= {SC_W{1'b0}};
      dwell_cnt_r   <= {DWELL_W{1'b0}};
      phi_r         <= {PHI_W{1'b0}};
      idx_r         <= 16'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      tone_valid_r  <= 1'b0;
      nco_reset_n_r <= 1'b0;
      nco_clken_r   <= 1'b0;
      err_r         <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      dir_r         <= 1'b0;
      rep_r         <= 8'd0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      start_inc_r   <= start_inc_nxt_s;
      step_r        <= step_nxt_s;
      stop_r        <= stop_nxt_s;
      dwell_r       <= dwell_nxt_s;
      rst_cnt_r     <= rst_cnt_nxt_s;
      settle_cnt_r  <= settle_cnt_nxt_s;
      dwell_cnt_r   <= dwell_cnt_nxt_s;
      phi_r         <= phi_nxt_s;
      idx_r         <= idx_nxt_s;
      busy_r        <= busy_nxt_s;
      done_r        <= done_nxt_s;
      tone_valid_r  <= tone_valid_nxt_s;
      nco_reset_n_r <= nco_reset_n_nxt_s;
      nco_clken_r   <= nco_clken_nxt_s;
      err_r         <= err_nxt_s;
`ifdef SWEEP_PINGPONG_EN
      dir_r         <= dir_nxt_s;
      rep_r         <= rep_nxt_s;
`endif
    end
  end

  assign nco_phi_inc = phi_r;
  assign nco_reset_n = nco_reset_n_r;
  assign nco_clken   = nco_clken_r;
  assign tone_valid  = tone_valid_r;
  assign tone_idx    = idx_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Testbench for nco_sweep_ctrl: scoreboard of expected tones and done events,
// a behavioural NCO that raises out_valid a set number of cycles after
// reset release, directed scenarios and randomized sweeps.
module tb_nco_sweep_ctrl;

  localparam int RST_CYC = 14;
  localparam int SET_MAX = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] cfg_start_inc;
  logic [31:0] cfg_step_inc;
  logic [31:0] cfg_stop_inc;
  logic [15:0] cfg_dwell;
  logic        nco_valid;
  logic [31:0] nco_phi_inc;
  logic        nco_reset_n;
  logic        nco_clken;
  logic        tone_valid;
  logic [15:0] tone_idx;
  logic        busy;
  logic        done;
  logic        err_timeout;

  nco_sweep_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_start_inc (cfg_start_inc),
    .cfg_step_inc  (cfg_step_inc),
    .cfg_stop_inc  (cfg_stop_inc),
    .cfg_dwell     (cfg_dwell),
`ifdef SWEEP_PINGPONG_EN
    .cfg_repeat    (8'd1),
`endif
    .nco_valid     (nco_valid),
    .nco_phi_inc   (nco_phi_inc),
    .nco_reset_n   (nco_reset_n),
    .nco_clken     (nco_clken),
    .tone_valid    (tone_valid),
    .tone_idx      (tone_idx),
    .busy          (busy),
    .done          (done),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_done;
    int              idx;
    longint unsigned phi;
    int              len;
    bit              err;
    int              rl;
    int              sh;
  } exp_t;

  exp_t scb_q[$];
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   done_cnt = 0;
  int   nco_lat  = 3;
  bit   nco_en   = 1'b1;
  int   nco_hi   = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_tone(input int idx, input longint unsigned phi, input int len);
    exp_t e;
    e.is_done = 1'b0; e.idx = idx; e.phi = phi; e.len = len;
    e.err = 1'b0; e.rl = 0; e.sh = 0;
    scb_q.push_back(e);
  endtask

  task automatic push_done(input bit err, input int rl, input int sh);
    exp_t e;
    e.is_done = 1'b1; e.idx = 0; e.phi = 0; e.len = 0;
    e.err = err; e.rl = rl; e.sh = sh;
    scb_q.push_back(e);
  endtask

  // Reference model: list every tone the sweep should produce, then its done.
  task automatic model_sweep(input logic [31:0] s, input logic [31:0] st, input logic [31:0] sp,
                             input logic [15:0] dw, input int lat, input bit en,
                             input int ab_tone, input int ab_cyc);
    longint unsigned phi;
    longint unsigned nx;
    int dl;
    if (!en) begin
      push_done(1'b1, RST_CYC, SET_MAX);
    end else begin
      phi = longint'(s);
      dl  = (dw == 16'd0) ? 1 : int'(dw);
      for (int k = 0; k < 4096; k++) begin
        push_tone(k, phi, (k == ab_tone) ? ab_cyc : dl);
        if (k == ab_tone) break;
        nx = phi + longint'(st);
        if (st == 32'd0 || nx > 64'hFFFF_FFFF || nx > longint'(sp)) break;
        phi = nx;
      end
      push_done(1'b0, RST_CYC, lat);
    end
  endtask

  // Behavioural NCO: out_valid after nco_lat cycles of reset_n high.
  initial begin
    nco_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!nco_reset_n) nco_hi = 0;
      else nco_hi++;
      nco_valid = nco_en && (nco_hi >= nco_lat);
    end
  end

  // Monitor state
  bit              m_prev_tv, m_prev_busy, m_seen_hi, m_seen_tv, m_post_done;
  int              m_idx, m_len, m_rl, m_sh;
  longint unsigned m_phi;

  task automatic finalize_tone();
    exp_t e;
    if (scb_q.size() == 0 || scb_q[0].is_done) begin
      n_vec++; n_bad++;
      $display("FAIL unexpected_tone: got idx %0d phi 0x%0h len %0d, expected none", m_idx, m_phi, m_len);
    end else begin
      e = scb_q.pop_front();
      chk("tone_idx", longint'(m_idx), longint'(e.idx));
      chk("tone_phi", m_phi, e.phi);
      chk("tone_len", longint'(m_len), longint'(e.len));
    end
  endtask

  task automatic handle_done();
    exp_t e;
    while (scb_q.size() != 0 && !scb_q[0].is_done) begin
      e = scb_q.pop_front();
      n_vec++; n_bad++;
      $display("FAIL missing_tone: got done, expected tone idx %0d", e.idx);
    end
    if (scb_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL unexpected_done: got done pulse, expected none");
    end else begin
      e = scb_q.pop_front();
      chk("done_err_timeout", longint'(err_timeout), longint'(e.err));
      chk("nco_reset_low_cycles", longint'(m_rl), longint'(e.rl));
      chk("settle_cycles", longint'(m_sh), longint'(e.sh));
    end
  endtask

  // Monitor: samples on the falling edge, assembles tones and done events.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_prev_tv = 1'b0; m_prev_busy = 1'b0; m_seen_hi = 1'b0;
        m_seen_tv = 1'b0; m_post_done = 1'b0;
        m_len = 0; m_rl = 0; m_sh = 0;
      end else begin
        if (m_post_done) begin
          chk("done_single_pulse", longint'(done), 0);
          chk("busy_after_done", longint'(busy), 0);
          m_post_done = 1'b0;
        end
        if (busy && !m_prev_busy) begin
          m_rl = 0; m_sh = 0; m_seen_hi = 1'b0; m_seen_tv = 1'b0;
        end
        if (busy && !nco_reset_n && !m_seen_hi) m_rl++;
        if (nco_reset_n) m_seen_hi = 1'b1;
        if (nco_reset_n && !tone_valid && !m_seen_tv) m_sh++;
        if (tone_valid) begin
          if (m_prev_tv && int'(tone_idx) == m_idx) begin
            m_len++;
          end else begin
            if (m_prev_tv) finalize_tone();
            m_idx = int'(tone_idx);
            m_phi = longint'(nco_phi_inc);
            m_len = 1;
          end
          m_seen_tv = 1'b1;
        end else if (m_prev_tv) begin
          finalize_tone();
        end
        if (done) begin
          handle_done();
          done_cnt++;
          m_post_done = 1'b1;
        end
        m_prev_tv   = tone_valid;
        m_prev_busy = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] st, input logic [31:0] sp,
                           input logic [15:0] dw, input int lat, input bit en,
                           input int ab_tone, input int ab_cyc, input bit dbl_start);
    int tgt;
    int cyc;
    int ab_cnt;
    cfg_start_inc = s; cfg_step_inc = st; cfg_stop_inc = sp; cfg_dwell = dw;
    nco_lat = lat; nco_en = en;
    model_sweep(s, st, sp, dw, lat, en, ab_tone, ab_cyc);
    tgt = done_cnt + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble the config so a design that fails to latch it is exposed.
    cfg_start_inc = $urandom; cfg_step_inc = $urandom; cfg_stop_inc = $urandom;
    cfg_dwell = 16'($urandom_range(7, 0));
    chk("err_cleared_by_start", longint'(err_timeout), 0);
    cyc = 0; ab_cnt = 0;
    while (done_cnt < tgt && cyc < 3000) begin
      start = (dbl_start && cyc == 3) ? 1'b1 : 1'b0;
      if (ab_tone >= 0 && tone_valid && int'(tone_idx) == ab_tone) begin
        ab_cnt++;
        abort = (ab_cnt == ab_cyc) ? 1'b1 : 1'b0;
      end else begin
        abort = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0; abort = 1'b0;
    if (cyc >= 3000) begin
      n_vec++; n_bad++;
      $display("FAIL sweep_timeout: got no done in %0d cycles, expected done", cyc);
    end
    tick();
    tick();
  endtask

  logic [31:0] r_s, r_st, r_sp;
  logic [63:0] r_tmp;
  int          r_n, wait_cyc;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_start_inc = 32'd0; cfg_step_inc = 32'd0; cfg_stop_inc = 32'd0; cfg_dwell = 16'd0;
    repeat (3) tick();
    chk("rst_phi_inc", longint'(nco_phi_inc), 0);
    chk("rst_nco_reset_n", longint'(nco_reset_n), 0);
    chk("rst_nco_clken", longint'(nco_clken), 0);
    chk("rst_tone_valid", longint'(tone_valid), 0);
    chk("rst_tone_idx", longint'(tone_idx), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err_timeout", longint'(err_timeout), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic 4-tone sweep.
    run_sweep(32'h0010_0000, 32'h0010_0000, 32'h0040_0000, 16'd10, 3, 1'b1, -1, 0, 1'b0);
    chk("final_phi_basic", longint'(nco_phi_inc), 64'h0040_0000);
    // Overflow ends the sweep after one tone.
    run_sweep(32'hFFF0_0000, 32'h0020_0000, 32'hFFFF_FFFF, 16'd4, 2, 1'b1, -1, 0, 1'b0);
    // Settle timeout, then the next start clears the sticky flag.
    run_sweep(32'h0010_0000, 32'h0010_0000, 32'h0040_0000, 16'd3, 3, 1'b0, -1, 0, 1'b0);
    chk("err_sticky", longint'(err_timeout), 1);
    run_sweep(32'h0010_0000, 32'h0010_0000, 32'h0040_0000, 16'd2, 4, 1'b1, -1, 0, 1'b0);
    // Abort in the 5th dwell cycle of tone 2.
    run_sweep(32'h0010_0000, 32'h0010_0000, 32'h0040_0000, 16'd10, 3, 1'b1, 2, 5, 1'b0);
    chk("abort_phi_frozen", longint'(nco_phi_inc), 64'h0030_0000);
    chk("abort_tone_valid", longint'(tone_valid), 0);
    // Start above stop: exactly one tone.
    run_sweep(32'h0050_0000, 32'h0010_0000, 32'h0040_0000, 16'd3, 1, 1'b1, -1, 0, 1'b0);
    // dwell=0, step=0, with a second start while busy.
    run_sweep(32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 16'd0, 2, 1'b1, -1, 0, 1'b1);

    // Reset in the middle of tone 1: tone 0 completes, no done afterwards.
    cfg_start_inc = 32'h0010_0000; cfg_step_inc = 32'h0010_0000;
    cfg_stop_inc = 32'h0100_0000; cfg_dwell = 16'd20; nco_lat = 2; nco_en = 1'b1;
    push_tone(0, 64'h0010_0000, 20);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc = 0;
    while (!(tone_valid && tone_idx == 16'd1) && wait_cyc < 500) begin
      tick(); wait_cyc++;
    end
    if (wait_cyc >= 500) begin
      n_vec++; n_bad++;
      $display("FAIL rst_wait_tone1: got no tone 1 in %0d cycles, expected tone 1", wait_cyc);
    end
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_phi_inc", longint'(nco_phi_inc), 0);
    chk("midrst_nco_reset_n", longint'(nco_reset_n), 0);
    chk("midrst_nco_clken", longint'(nco_clken), 0);
    chk("midrst_tone_valid", longint'(tone_valid), 0);
    chk("midrst_tone_idx", longint'(tone_idx), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_err_timeout", longint'(err_timeout), 0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_no_done", longint'(done), 0);
    end
    chk("postrst_scb_empty", longint'(scb_q.size()), 0);
    run_sweep(32'h0010_0000, 32'h0010_0000, 32'h0040_0000, 16'd10, 3, 1'b1, -1, 0, 1'b0);

    // Randomized sweeps.
    for (int it = 0; it < 10; it++) begin
      r_s  = $urandom;
      r_st = $urandom_range(32'h0100_0000, 32'h0001_0000);
      r_n  = int'($urandom_range(5, 0));
      r_tmp = {32'd0, r_s} + ({32'd0, r_st} * r_n) + {32'd0, 32'($urandom_range(r_st - 32'd1, 32'd0))};
      r_sp = r_tmp[31:0];
      run_sweep(r_s, r_st, r_sp, 16'($urandom_range(5, 0)), int'($urandom_range(6, 1)),
                1'b1, -1, 0, 1'b0);
    end

    chk("scb_empty", longint'(scb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
